ball_round_ctrl: RTL

//  Game sequencer for the reflex trainer. Schedules target-ball rounds and

---
 rtl/ball_round_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ball_round_ctrl.sv
// Reflex-trainer round sequencer: random inter-round delay, pseudo-random ball
// placement, click hit-box test, score and reaction-time bookkeeping.
module ball_round_ctrl #(
  parameter int BALL_R     = 16,
  parameter int TIMEOUT_F  = 90,
  parameter int MIN_DELAY  = 30,
  parameter int DELAY_MASK = 63,
  parameter int ROUNDS     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       MOUSE_LEFT,
  input  logic [9:0] MOUSE_X_POS,
  input  logic [9:0] MOUSE_Y_POS,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       enable_ball,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score,
  output logic [7:0] last_rt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHOW, S_DONE} state_t;

  localparam logic signed [10:0] R_S    = 11'(BALL_R);
  localparam logic [8:0]         Y_FOLD = 9'(480 - 2 * BALL_R);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_lfsr;
  logic        r_left_q;
  logic [7:0]  r_cnt;
  logic [7:0]  r_frcnt;
  logic [7:0]  r_round;
  logic [7:0]  r_score;
  logic [7:0]  r_last_rt;
  logic        r_hit;
  logic        r_miss;
  logic [9:0]  r_ball_x;
  logic [9:0]  r_ball_y;

  logic              w_fb;
  logic [7:0]        w_delay;
  logic [8:0]        w_y_raw;
  logic [8:0]        w_y_fold;
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic              w_in_box;
  logic              w_click;
  logic              w_timeout;
  logic              w_start_game;
  logic              w_load_delay;
  logic              w_latch_pos;
  logic              w_hit;
  logic              w_miss;

  assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_delay = 8'(MIN_DELAY) + {2'b00, r_lfsr[5:0] & 6'(DELAY_MASK)};

  // Fold tall y values back by 256 so the whole hit box stays on a 480-line screen.
  assign w_y_raw  = r_lfsr[15:7];
  assign w_y_fold = (w_y_raw >= Y_FOLD) ? (w_y_raw - 9'd256) : w_y_raw;

  assign w_dx      = $signed({1'b0, MOUSE_X_POS}) - $signed({1'b0, r_ball_x});
  assign w_dy      = $signed({1'b0, MOUSE_Y_POS}) - $signed({1'b0, r_ball_y});
  assign w_in_box  = (w_dx <= R_S) && (w_dx >= -R_S) && (w_dy <= R_S) && (w_dy >= -R_S);
  assign w_click   = MOUSE_LEFT & ~r_left_q;
  assign w_timeout = frame_tick && (r_frcnt == 8'(TIMEOUT_F - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_start_game = 1'b0;
    w_load_delay = 1'b0;
    w_latch_pos  = 1'b0;
    w_hit        = 1'b0;
    w_miss       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next       = S_WAIT;
          w_start_game = 1'b1;
          w_load_delay = 1'b1;
        end
      end
      S_WAIT: begin
        if (frame_tick && (r_cnt == 8'd0)) begin
          w_next      = S_SHOW;
          w_latch_pos = 1'b1;
        end
      end
      S_SHOW: begin
        // A hit wins over a timeout landing in the same cycle.
        if (w_click && w_in_box) w_hit  = 1'b1;
        else if (w_timeout)      w_miss = 1'b1;
        if (w_hit || w_miss) begin
          if (r_round == 8'(ROUNDS - 1)) begin
            w_next = S_DONE;
          end else begin
            w_next       = S_WAIT;
            w_load_delay = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr    <= 16'hACE1;
      r_left_q  <= 1'b0;
      r_cnt     <= 8'd0;
      r_frcnt   <= 8'd0;
      r_round   <= 8'd0;
      r_score   <= 8'd0;
      r_last_rt <= 8'd0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_ball_x  <= 10'd0;
      r_ball_y  <= 10'd0;
    end else begin
      r_lfsr   <= {r_lfsr[14:0], w_fb};
      r_left_q <= MOUSE_LEFT;
      r_hit    <= w_hit;
      r_miss   <= w_miss;

      if (w_start_game) begin
        r_score <= 8'd0;
        r_round <= 8'd0;
      end else begin
        if (w_hit)           r_score <= r_score + 8'd1;
        if (w_hit || w_miss) r_round <= r_round + 8'd1;
      end

      if (w_hit) r_last_rt <= r_frcnt;

      if (w_load_delay)
        r_cnt <= w_delay;
      else if ((r_state == S_WAIT) && frame_tick && (r_cnt != 8'd0))
        r_cnt <= r_cnt - 8'd1;

      if (w_latch_pos) begin
        r_ball_x <= 10'(BALL_R) + {1'b0, r_lfsr[8:0]};
        r_ball_y <= 10'(BALL_R) + {1'b0, w_y_fold};
        r_frcnt  <= 8'd0;
      end else if ((r_state == S_SHOW) && frame_tick && (r_frcnt != 8'hFF)) begin
        r_frcnt <= r_frcnt + 8'd1;
      end
    end
  end

  assign ball_x      = r_ball_x;
  assign ball_y      = r_ball_y;
  assign enable_ball = (r_state == S_SHOW);
  assign hit         = r_hit;
  assign miss        = r_miss;
  assign score       = r_score;
  assign last_rt     = r_last_rt;
  assign busy        = (r_state == S_WAIT) || (r_state == S_SHOW);
  assign done        = (r_state == S_DONE);

endmodule
